// File: rtl/atom_clk_pkg.sv
// Shared constants and types for the Atom PHI2 clock generator.
package atom_clk_pkg;

  // Master (16 MHz) clocks per PHI2 half-period
  localparam int SLOW_HALF_DEF    = 8;   // 1 MHz CPU cycle
  localparam int FAST_HALF_DEF    = 4;   // 2 MHz CPU cycle

  // Low-phase clock at which Addr is inspected for the I/O page
  localparam int ADDR_SAMPLE_DEF  = 2;

  // PHI2 cycles the CPU is held in reset after board reset
  localparam int RESET_CYCLES_DEF = 8;

  // $B000-$BFFF I/O page, matched on Addr[15:12]
  localparam logic [3:0] IO_PAGE  = 4'hB;

  // PHI2 phase; the encoding matches the PHI2 level
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

endpackage

// File: rtl/phi2_clock_gen_sync2.sv
// Two-flop synchroniser with synchronous active-low reset.
module sync2 (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the asynchronous input twice before use
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/phi2_clock_gen.sv
// PHI2 clock generator for the Atom RAM/ROM board.
// Divides the 16 MHz master clock to a 1 MHz or 2 MHz PHI2, picks the speed
// once per cycle at the falling edge, and holds the CPU in reset for a fixed
// number of PHI2 cycles after board reset.
// Build option: define IO_STRETCH_EN to stretch fast cycles that address the
// $B000-$BFFF I/O page back to slow timing.
//
//   state   | meaning
//   --------+------------------------------------------------
//   PH_LOW  | PHI2 low; address sampled here for I/O stretch
//   PH_HIGH | PHI2 high; the falling edge ends the CPU cycle
module phi2_clock_gen
  import atom_clk_pkg::*;
#(
  parameter int SLOW_HALF    = SLOW_HALF_DEF,
  parameter int FAST_HALF    = FAST_HALF_DEF,
  parameter int ADDR_SAMPLE  = ADDR_SAMPLE_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        NReset,
  input  logic        SpeedSW,
  input  logic [15:0] Addr,
  output logic        PHI2,
  output logic        CycleEnd,
  output logic        Fast,
  output logic        Stretched,
  output logic        NCpuRes
);

  localparam logic [3:0] SLOW_LEN   = 4'(SLOW_HALF);
  localparam logic [3:0] FAST_LEN   = 4'(FAST_HALF);
  localparam logic [3:0] SAMPLE_CNT = 4'(ADDR_SAMPLE);
  localparam int         RES_W      = $clog2(RESET_CYCLES + 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESET_CYCLES - 1);

  phase_e           state;
  logic [3:0]       phase_cnt;
  logic [3:0]       half_len;
  logic [RES_W-1:0] res_cnt;
  logic             speed_sync;
  logic             phase_done;
  logic             cycle_start;
  logic             io_hit;

  sync2 u_speed_sync (
    .clk_sys (Clk),
    .rst_b   (NReset),
    .d       (SpeedSW),
    .q       (speed_sync)
  );

  assign phase_done  = (phase_cnt == half_len - 4'd1);
  assign cycle_start = phase_done && (state == PH_HIGH);

`ifdef IO_STRETCH_EN
  logic stretched_q;
  logic addr_unused;

  // A fast cycle touching the I/O page is detected at one fixed low-phase clock
  assign io_hit = (state == PH_LOW) && (phase_cnt == SAMPLE_CNT) && Fast &&
                  (Addr[15:12] == IO_PAGE);
  assign addr_unused = ^Addr[11:0];

  // Flag the stretched cycle from the sample clock until the next falling edge
  always_ff @(posedge Clk) begin
    if (!NReset) begin
      stretched_q <= 1'b0;
    end else if (cycle_start) begin
      stretched_q <= 1'b0;
    end else if (io_hit) begin
      stretched_q <= 1'b1;
    end
  end

  assign Stretched = stretched_q;
`else
  logic cfg_unused;

  // Without stretching, Addr and the sample point have no effect
  assign io_hit     = 1'b0;
  assign cfg_unused = ^{Addr, SAMPLE_CNT};
  assign Stretched  = 1'b0;
`endif

  // Phase FSM: counts each half-period and latches the speed at the falling edge
  always_ff @(posedge Clk) begin
    if (!NReset) begin
      state     <= PH_LOW;
      PHI2      <= 1'b0;
      phase_cnt <= 4'd0;
      half_len  <= SLOW_LEN;
      Fast      <= 1'b0;
      CycleEnd  <= 1'b0;
    end else begin
      CycleEnd <= 1'b0;
      if (phase_done) begin
        phase_cnt <= 4'd0;
        if (state == PH_HIGH) begin
          state    <= PH_LOW;
          PHI2     <= 1'b0;
          CycleEnd <= 1'b1;
          Fast     <= speed_sync;
          half_len <= speed_sync ? FAST_LEN : SLOW_LEN;
        end else begin
          state <= PH_HIGH;
          PHI2  <= 1'b1;
        end
      end else begin
        phase_cnt <= phase_cnt + 4'd1;
        // Stretch covers the rest of this low phase and the whole high phase
        if (io_hit) begin
          half_len <= SLOW_LEN;
        end
      end
    end
  end

  // CPU reset release after a fixed count of completed PHI2 cycles
  always_ff @(posedge Clk) begin
    if (!NReset) begin
      res_cnt <= '0;
      NCpuRes <= 1'b0;
    end else if (cycle_start && !NCpuRes) begin
      if (res_cnt == RES_LAST) begin
        NCpuRes <= 1'b1;
      end else begin
        res_cnt <= res_cnt + RES_W'(1);
      end
    end
  end

endmodule
